// File: rtl/ram_sync.sv
// Single-port synchronous RAM with a self-clearing INIT phase after reset,
// pipelined reads of configurable latency and range checking on every request.
module ram_sync #(
   parameter int DATA_W = 20,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              str,
   input  logic              ld,
   output logic [DATA_W-1:0] rdata,
   output logic              rd_valid,
   output logic              ready,
   output logic              err
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t              state_reg;
   state_t              state_next;
   logic [ADDR_W-1:0]   clr_cnt_reg;
   logic [ADDR_W-1:0]   clr_cnt_next;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                in_range;
   logic                req;
   logic                acc;
   logic                rd_en;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;

   logic [DATA_W-1:0]   pipe_data_reg [RD_LAT];
   logic [RD_LAT-1:0]   pipe_vld_reg;
   logic                err_reg;

   assign ready    = (state_reg == ST_RUN);
   assign in_range = ({1'b0, addr} < DEPTH_L);
   assign req      = ready && (str || ld);
   assign acc      = rst_n && req && in_range;
   assign rd_en    = acc && ld;

   // ------------------------------------------------------------------
   // State register and clear counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_INIT;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      case (state_reg)
         ST_INIT: begin
            if (clr_cnt_reg == LAST_ADDR) begin
               state_next   = ST_RUN;
               clr_cnt_next = '0;
            end else begin
               clr_cnt_next = clr_cnt_reg + 1'b1;
            end
         end
         ST_RUN: begin
            state_next   = ST_RUN;
         end
         default: begin
            state_next   = ST_INIT;
            clr_cnt_next = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Memory write port: clear sweep during INIT, user writes during RUN
   // ------------------------------------------------------------------
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = addr;
      wr_data = wdata;
      if (rst_n) begin
         if (state_reg == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt_reg;
            wr_data = '0;
         end else if (acc && str) begin
            wr_en   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Read pipeline. Stage 0 samples the array on the request edge, so a
   // same-cycle write is not yet visible (read-before-write). Later stages
   // only load when valid data arrives, which makes rdata hold otherwise.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_data_reg[i] <= '0;
         end
         pipe_vld_reg <= '0;
      end else begin
         pipe_vld_reg[0] <= rd_en;
         if (rd_en) begin
            pipe_data_reg[0] <= mem[addr];
         end
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_reg[i] <= pipe_vld_reg[i-1];
            if (pipe_vld_reg[i-1]) begin
               pipe_data_reg[i] <= pipe_data_reg[i-1];
            end
         end
      end
   end

   assign rdata    = pipe_data_reg[RD_LAT-1];
   assign rd_valid = pipe_vld_reg[RD_LAT-1];

   // ------------------------------------------------------------------
   // Out-of-range flag: one-cycle pulse, requests in INIT never raise it
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= req && !in_range;
      end
   end

   assign err = err_reg;

endmodule

// File: tb/tb_ram_sync.sv
// Scoreboarded bench for ram_sync: two instances (default, and DEPTH=1000 with
// RD_LAT=2) share one randomized/directed stimulus stream against an array model.
module tb_ram_sync;

   typedef struct packed {
      int          due;
      logic [19:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        str = 1'b0;
   logic        ld = 1'b0;
   logic [9:0]  addr = '0;
   logic [19:0] wdata = '0;

   logic [19:0] rdata0, rdata1;
   logic        rd_valid0, rd_valid1;
   logic        ready0, ready1;
   logic        err0, err1;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          armed = 1'b0;

   logic [19:0] m_mem [2][1024];
   int          m_left [2];
   bit          m_ready [2];
   logic [19:0] m_last [2];
   exp_t        rq0[$], rq1[$];
   int          eq0[$], eq1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_sync #(.DATA_W(20), .ADDR_W(10), .DEPTH(1024), .RD_LAT(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .str(str), .ld(ld),
      .rdata(rdata0), .rd_valid(rd_valid0), .ready(ready0), .err(err0)
   );

   ram_sync #(.DATA_W(20), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .str(str), .ld(ld),
      .rdata(rdata1), .rd_valid(rd_valid1), .ready(ready1), .err(err1)
   );

   function automatic int dep(int d);
      return (d == 0) ? 1024 : 1000;
   endfunction

   function automatic int lat(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cyc, act, exp);
      end
   endtask

   // One stimulus cycle: drive inputs, then advance the model to the next cycle.
   task automatic step(input logic s, input logic l, input logic [9:0] a,
                       input logic [19:0] w, input logic rn);
      exp_t e;
      @(negedge clk);
      #1;
      str = s; ld = l; addr = a; wdata = w; rst_n = rn;
      for (int d = 0; d < 2; d++) begin
         if (!rn) begin
            m_left[d]  = dep(d);
            m_ready[d] = 1'b0;
            m_last[d]  = '0;
            if (d == 0) begin rq0.delete(); eq0.delete(); end
            else        begin rq1.delete(); eq1.delete(); end
         end else if (!m_ready[d]) begin
            m_left[d]--;
            if (m_left[d] == 0) begin
               m_ready[d] = 1'b1;
               for (int k = 0; k < 1024; k++) m_mem[d][k] = '0;
            end
         end else if (s || l) begin
            if (int'(a) < dep(d)) begin
               if (l) begin
                  e.due  = cyc + lat(d);
                  e.data = m_mem[d][a];
                  if (d == 0) rq0.push_back(e); else rq1.push_back(e);
               end
               if (s) m_mem[d][a] = w;
            end else begin
               if (d == 0) eq0.push_back(cyc + 1); else eq1.push_back(cyc + 1);
            end
         end
      end
      if (!rn) armed = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, 20'd0, 1'b1);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 1100 && !(m_ready[0] && m_ready[1]); i++) idle(1);
   endtask

   task automatic check_dut(int d, logic rdv, logic [19:0] rd, logic rdy, logic er);
      exp_t e;
      bit   have;
      bit   exp_err;
      e = '0;
      chk("ready", d, 32'(rdy), 32'(m_ready[d]));
      have = (d == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
      if (have) e = (d == 0) ? rq0[0] : rq1[0];
      if (rdv) begin
         if (!have) begin
            chk("rd_valid_unexpected", d, 32'd1, 32'd0);
         end else begin
            if (d == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
            chk("rd_cycle", d, cyc, e.due);
            chk("rdata", d, 32'(rd), 32'(e.data));
            m_last[d] = e.data;
         end
      end else begin
         chk("rdata_hold", d, 32'(rd), 32'(m_last[d]));
         if (have && e.due <= cyc) begin
            chk("rd_valid_missing", d, 32'd0, 32'd1);
            if (d == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
         end
      end
      if (d == 0) exp_err = (eq0.size() > 0) && (eq0[0] == cyc);
      else        exp_err = (eq1.size() > 0) && (eq1[0] == cyc);
      if (exp_err) begin
         if (d == 0) void'(eq0.pop_front()); else void'(eq1.pop_front());
      end
      chk("err", d, 32'(er), 32'(exp_err));
   endtask

   always @(negedge clk) begin
      if (armed) begin
         check_dut(0, rd_valid0, rdata0, ready0, err0);
         check_dut(1, rd_valid1, rdata1, ready1, err1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_left[d] = 0; m_ready[d] = 1'b0; m_last[d] = '0;
      end

      // Reset, then clear phase with requests that must be ignored early on.
      step(1'b0, 1'b0, 10'd0, 20'd0, 1'b0);
      step(1'b0, 1'b0, 10'd0, 20'd0, 1'b0);
      for (int i = 0; i < 1100 && !(m_ready[0] && m_ready[1]); i++) begin
         if (i < 900) step(1'($urandom), 1'($urandom), 10'($urandom), 20'($urandom), 1'b1);
         else         idle(1);
      end

      // Cleared contents
      step(1'b0, 1'b1, 10'd0,    20'd0, 1'b1);
      step(1'b0, 1'b1, 10'd511,  20'd0, 1'b1);
      step(1'b0, 1'b1, 10'd1023, 20'd0, 1'b1);
      idle(3);

      // Write then read next cycle
      step(1'b1, 1'b0, 10'd5, 20'hABCDE, 1'b1);
      step(1'b0, 1'b1, 10'd5, 20'd0,     1'b1);
      idle(3);

      // Same-cycle read and write returns old data
      step(1'b1, 1'b0, 10'd7, 20'h11111, 1'b1);
      step(1'b1, 1'b1, 10'd7, 20'h22222, 1'b1);
      step(1'b0, 1'b1, 10'd7, 20'd0,     1'b1);
      idle(3);

      // Range errors on the DEPTH=1000 instance
      step(1'b1, 1'b0, 10'd1000, 20'h55555, 1'b1);
      step(1'b0, 1'b1, 10'd0,    20'd0,     1'b1);
      step(1'b0, 1'b1, 10'd1023, 20'd0,     1'b1);
      step(1'b0, 1'b1, 10'd999,  20'd0,     1'b1);
      idle(3);

      // Streaming reads
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 10'(i), 20'(i * 3), 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 10'(i), 20'd0, 1'b1);
      idle(4);

      // Reset one cycle after a read
      step(1'b0, 1'b1, 10'd5, 20'd0, 1'b1);
      step(1'b0, 1'b0, 10'd0, 20'd0, 1'b0);
      wait_ready();

      // Reset in the middle of the clear sweep
      step(1'b0, 1'b0, 10'd0, 20'd0, 1'b0);
      idle(500);
      step(1'b0, 1'b0, 10'd0, 20'd0, 1'b0);
      wait_ready();

      // Random traffic, mostly on a small address window to get hits
      for (int i = 0; i < 3000; i++) begin
         logic [9:0] a;
         a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
         if ($urandom_range(0, 799) == 0) begin
            step(1'b0, 1'b0, 10'd0, 20'd0, 1'b0);
            wait_ready();
         end else begin
            step(1'($urandom), 1'($urandom), a, 20'($urandom), 1'b1);
         end
      end
      idle(5);

      chk("reads_drained", 0, 32'(rq0.size()), 32'd0);
      chk("reads_drained", 1, 32'(rq1.size()), 32'd0);
      chk("errs_drained",  0, 32'(eq0.size()), 32'd0);
      chk("errs_drained",  1, 32'(eq1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
